aes_inv_key_schedule: RTL and testbench

Sequential inverse AES key schedule for the decryption datapath. It is loaded with the final NK words of the expanded key schedule and regenerates earlier words one per cycle. Round keys are emitted in decryption order, NR down to 0, over a valid/ready stream. Full-schedule storage is not needed: the block holds only an NK-word sliding window, so it feeds the inverse-cipher round engine directly.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_inv_key_schedule_if.sv | 23 ++
 rtl/aes_inv_key_step.sv | 24 ++
 rtl/aes_inv_key_schedule.sv | 140 ++++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule primitives: S-box, RotWord, SubWord, Rcon, word and FSM state types.
package aes_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Forward S-box, entry x at bits [8x : 8x+7]
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[32'(x) * 8 +: 8];
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Load request and round-key stream between the key schedule (slave) and its controller/consumer (master).
interface aes_inv_key_schedule_if #(
    parameter int unsigned NK = 4
);
    logic                start;
    logic [0:32*NK-1]    last_key;
    logic                busy;
    logic                rk_valid;
    logic                rk_ready;
    logic [0:127]        rk_data;
    logic [3:0]          rk_index;
    logic                done;

    modport master (
        output start, last_key, rk_ready,
        input  busy, rk_valid, rk_data, rk_index, done
    );

    modport slave (
        input  start, last_key, rk_ready,
        output busy, rk_valid, rk_data, rk_index, done
    );
endinterface

// File: rtl/aes_inv_key_step.sv
// One backward key-expansion step: recovers w[j-NK] from w[j] and w[j-1].
module aes_inv_key_step
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned JW = 6
) (
    input  word_t          w_j,
    input  word_t          w_jm1,
    input  logic [JW-1:0]  j,
    output word_t          w_jmnk_c
);
    word_t t_c;

    always_comb begin
        t_c = w_jm1;
        if (32'(j) % NK == 0) begin
            t_c = sub_word(rot_word(w_jm1)) ^ rcon(4'(32'(j) / NK));
        end else if (NK > 6 && 32'(j) % NK == 4) begin
            t_c = sub_word(w_jm1);
        end
        w_jmnk_c = w_j ^ t_c;
    end
endmodule

// File: rtl/aes_inv_key_schedule.sv
// Inverse AES key schedule: emits round keys NR..0 from a sliding NK-word window.
// Optional KEYSCHED_ZEROIZE_EN clears window, rk_data and rk_index when round key 0 transfers.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_inv_key_schedule_if.slave bus
);
    localparam int unsigned IW = $clog2(4 * (NR + 1));
    localparam int unsigned RW = IW + 1;
    localparam logic [IW-1:0] B_INIT = IW'(4 * (NR + 1) - NK);

    state_e        state_q, state_d;
    word_t         win_q [NK];
    word_t         win_d [NK];
    logic [IW-1:0] b_q, b_d;
    logic [3:0]    next_r_q, next_r_d;
    logic          fin_q, fin_d;
    logic          rk_valid_q, rk_valid_d;
    logic [0:127]  rk_data_q, rk_data_d;
    logic [3:0]    rk_index_q, rk_index_d;
    logic          done_q, done_d;

    logic [RW-1:0] r4_c;
    logic [IW-1:0] off_c, j_c;
    logic          slot_free_c, xfer_c, emit_c, step_c;
    word_t         new_c;

    assign r4_c        = RW'({next_r_q, 2'b00});
    assign off_c       = IW'(r4_c - {1'b0, b_q});
    assign j_c         = b_q + IW'(NK - 1);
    assign slot_free_c = !rk_valid_q || bus.rk_ready;
    assign xfer_c      = rk_valid_q && bus.rk_ready;
    // After round key 0 is emitted the window is exhausted; only its transfer remains
    assign emit_c      = (state_q == ST_RUN) && !fin_q && (r4_c >= {1'b0, b_q});
    assign step_c      = (state_q == ST_RUN) && !fin_q && (r4_c <  {1'b0, b_q});

    aes_inv_key_step #(.NK(NK), .JW(IW)) u_step (
        .w_j      (win_q[NK-1]),
        .w_jm1    (win_q[NK-2]),
        .j        (j_c),
        .w_jmnk_c (new_c)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        b_d        = b_q;
        next_r_d   = next_r_q;
        fin_d      = fin_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_index_d = rk_index_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int unsigned i = 0; i < NK; i++) begin
                        win_d[i] = bus.last_key[32*i +: 32];
                    end
                    b_d      = B_INIT;
                    next_r_d = 4'(NR);
                    fin_d    = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer_c) begin
                    rk_valid_d = 1'b0;
                end
                if (emit_c && slot_free_c) begin
                    for (int unsigned k = 0; k + 4 <= NK; k++) begin
                        if (off_c == IW'(k)) begin
                            rk_data_d = {win_q[k], win_q[k+1], win_q[k+2], win_q[k+3]};
                        end
                    end
                    rk_index_d = next_r_q;
                    rk_valid_d = 1'b1;
                    next_r_d   = next_r_q - 4'd1;
                    fin_d      = (next_r_q == 4'd0);
                end else if (step_c) begin
                    win_d[0] = new_c;
                    for (int unsigned i = 1; i < NK; i++) begin
                        win_d[i] = win_q[i-1];
                    end
                    b_d = b_q - IW'(1);
                end
                if (fin_q && xfer_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`ifdef KEYSCHED_ZEROIZE_EN
                    for (int unsigned i = 0; i < NK; i++) begin
                        win_d[i] = '0;
                    end
                    rk_data_d  = '0;
                    rk_index_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            for (int unsigned i = 0; i < NK; i++) begin
                win_q[i] <= '0;
            end
            b_q        <= '0;
            next_r_q   <= '0;
            fin_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_index_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            b_q        <= b_d;
            next_r_q   <= next_r_d;
            fin_q      <= fin_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_index_q <= rk_index_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
    assign bus.rk_index = rk_index_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule: AES-128/192/256 instances checked against a forward key-expansion model.
module tb_aes_inv_key_schedule;
    import aes_pkg::*;

    logic         clk, rst, start_r, ready;
    int           sel, checks, failures, last_xfer;
    int           vis_cyc [16];
    logic [0:127] cap [16];
    logic [31:0]  kw [8];
    logic [31:0]  ew [60];
    logic         cur_valid, cur_done, cur_busy;
    logic [3:0]   cur_idx;
    logic [0:127] cur_data;

    aes_inv_key_schedule_if #(.NK(4)) bus4 ();
    aes_inv_key_schedule_if #(.NK(6)) bus6 ();
    aes_inv_key_schedule_if #(.NK(8)) bus8 ();

    aes_inv_key_schedule #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    aes_inv_key_schedule #(.NK(6), .NR(12)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
    aes_inv_key_schedule #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    assign bus4.start    = start_r && (sel == 0);
    assign bus6.start    = start_r && (sel == 1);
    assign bus8.start    = start_r && (sel == 2);
    assign bus4.rk_ready = ready;
    assign bus6.rk_ready = ready;
    assign bus8.rk_ready = ready;

    always_comb begin
        case (sel)
            0: begin
                cur_valid = bus4.rk_valid; cur_done = bus4.done; cur_busy = bus4.busy;
                cur_idx   = bus4.rk_index; cur_data = bus4.rk_data;
            end
            1: begin
                cur_valid = bus6.rk_valid; cur_done = bus6.done; cur_busy = bus6.busy;
                cur_idx   = bus6.rk_index; cur_data = bus6.rk_data;
            end
            default: begin
                cur_valid = bus8.rk_valid; cur_done = bus8.done; cur_busy = bus8.busy;
                cur_idx   = bus8.rk_index; cur_data = bus8.rk_data;
            end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_sub(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Forward FIPS-197 key expansion of kw into ew
    task automatic expand(input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) ew[i] = '0;
        for (int i = 0; i < nk; i++) ew[i] = kw[i];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = ew[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int k = 1; k < i / nk; k++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                t = tb_sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = tb_sub(t);
            end
            ew[i] = ew[i-nk] ^ t;
        end
    endtask

    function automatic logic [0:127] exp_rk(input int r);
        return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
    endfunction

    task automatic load(input int s, input int nk, input int nr);
        int base;
        base = 4 * (nr + 1) - nk;
        for (int i = 0; i < nk; i++) begin
            case (s)
                0:       bus4.last_key[32*i +: 32] = ew[base+i];
                1:       bus6.last_key[32*i +: 32] = ew[base+i];
                default: bus8.last_key[32*i +: 32] = ew[base+i];
            endcase
        end
    endtask

    task automatic chk_outs_zero(input string pfx);
        chk({pfx, "_rk_valid"}, 128'(cur_valid), 128'd0);
        chk({pfx, "_rk_data"},  cur_data,        128'd0);
        chk({pfx, "_rk_index"}, 128'(cur_idx),   128'd0);
        chk({pfx, "_done"},     128'(cur_done),  128'd0);
        chk({pfx, "_busy"},     128'(cur_busy),  128'd0);
    endtask

    // Start one full schedule run and compare every transferred round key with the model
    task automatic run_key(input int s, input int nr, input int stall_r, input int stall_n, input bit poke);
        int           exp_r, cyc, stall_left, n_xfer, done_cnt;
        bit           held_v;
        logic [0:127] held, zexp;
        sel = s; ready = 1'b1; exp_r = nr; stall_left = stall_n;
        n_xfer = 0; done_cnt = 0; held_v = 1'b0; held = '0; last_xfer = -1;
        for (int i = 0; i < 16; i++) begin
            vis_cyc[i] = -1;
            cap[i]     = '0;
        end
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        cyc = 0;
        chk("busy_after_start", 128'(cur_busy), 128'd1);
        while (done_cnt == 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            start_r = poke && (cyc == 20);
            if (cur_done) begin
                done_cnt++;
                chk("done_cycle", 128'(cyc), 128'(last_xfer));
            end
            if (cur_valid) begin
                if (vis_cyc[cur_idx] < 0) vis_cyc[cur_idx] = cyc;
                if (int'(cur_idx) == stall_r && stall_left > 0) begin
                    if (held_v) chk("stall_rk_data", cur_data, held);
                    else begin held = cur_data; held_v = 1'b1; end
                    ready = 1'b0;
                    stall_left--;
                end else begin
                    ready = 1'b1;
                end
                if (ready && exp_r >= 0) begin
                    chk("rk_index", 128'(cur_idx), 128'(exp_r));
                    chk("rk_data", cur_data, exp_rk(exp_r));
                    cap[cur_idx] = cur_data;
                    if (cur_idx == 4'd0) last_xfer = cyc + 1;
                    exp_r--;
                    n_xfer++;
                end
            end else begin
                ready = 1'b1;
            end
        end
        ready = 1'b1;
        chk("done_count", 128'(done_cnt), 128'd1);
        chk("xfer_count", 128'(n_xfer), 128'(nr + 1));
        chk("busy_after_done", 128'(cur_busy), 128'd0);
        chk("valid_after_done", 128'(cur_valid), 128'd0);
        chk("index_after_done", 128'(cur_idx), 128'd0);
`ifdef KEYSCHED_ZEROIZE_EN
        zexp = '0;
`else
        zexp = exp_rk(0);
`endif
        chk("idle_rk_data", cur_data, zexp);
        @(posedge clk); #1;
        chk("done_pulse_width", 128'(cur_done), 128'd0);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; sel = 0; start_r = 1'b0; ready = 1'b1; rst = 1'b1;
        last_xfer = -1;
        bus4.last_key = '0; bus6.last_key = '0; bus8.last_key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // AES-128, consumer always ready
        kw = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 32'h0, 32'h0, 32'h0, 32'h0};
        expand(4, 10);
        chk("model_rk10", exp_rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_rk9",  exp_rk(9),  128'hac7766f319fadc2128d12941575c006e);
        load(0, 4, 10);
        run_key(0, 10, -1, 0, 1'b0);
        chk("a128_rk10_cycle", 128'(vis_cyc[10]), 128'd1);
        chk("a128_rk0_cycle",  128'(vis_cyc[0]),  128'd51);
        chk("a128_xfer0_edge", 128'(last_xfer),   128'd52);
        chk("a128_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a128_rk1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("a128_rk0",  cap[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Backpressure on round key 9 for 7 cycles
        run_key(0, 10, 9, 7, 1'b0);
        chk("bp_rk9_cycle", 128'(vis_cyc[9]), 128'd6);
        chk("bp_rk8_cycle", 128'(vis_cyc[8]), 128'd14);
        chk("bp_rk0_cycle", 128'(vis_cyc[0]), 128'd54);
        chk("bp_rk0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // start pulsed while RUN must be ignored
        run_key(0, 10, -1, 0, 1'b1);
        chk("poke_rk0_cycle", 128'(vis_cyc[0]), 128'd51);

        // AES-256
        kw = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
               32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        expand(8, 14);
        chk("model_rk14", exp_rk(14), 128'hfe4890d1e6188d0b046df344706c631e);
        load(2, 8, 14);
        run_key(2, 14, -1, 0, 1'b0);
        chk("a256_rk14_cycle", 128'(vis_cyc[14]), 128'd1);
        chk("a256_rk13_cycle", 128'(vis_cyc[13]), 128'd2);
        chk("a256_rk0", cap[0], 128'h603deb1015ca71be2b73aef0857d7781);

        // AES-192
        kw = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
               32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
        expand(6, 12);
        chk("model_rk12", exp_rk(12), 128'he98ba06f448c773c8ecc720401002202);
        load(1, 6, 12);
        run_key(1, 12, -1, 0, 1'b0);
        chk("a192_rk12_cycle", 128'(vis_cyc[12]), 128'd1);
        chk("a192_rk0", cap[0], 128'h8e73b0f7da0e6452c810f32b809079e5);

        // Asynchronous reset while round key 5 is presented, then a clean rerun
        kw = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 32'h0, 32'h0, 32'h0, 32'h0};
        expand(4, 10);
        load(0, 4, 10);
        sel = 0; ready = 1'b1;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        n = 0;
        while (!(cur_valid && cur_idx == 4'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_rk5", 128'(cur_idx), 128'd5);
        rst = 1'b1;
        #1;
        chk_outs_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_key(0, 10, -1, 0, 1'b0);
        chk("rerun_rk0_cycle", 128'(vis_cyc[0]), 128'd51);
        chk("rerun_rk0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
